seq_mult: RTL and testbench

Parametrised sequential unsigned multiplier: the next generation of the fixed 2x2 combinational `main` multiplier. It computes `A*B` for any operand width using a shift-add datapath, one multiplier bit per clock. A start/busy/done handshake lets a controller or bench launch operations and collect results. It is a reusable arithmetic leaf for the board-level designs.

---
 rtl/mult_pkg.sv | 16 +
 rtl/seq_mult_dp.sv | 39 +++
 rtl/seq_mult.sv | 92 +++++++++
 tb/tb_seq_mult.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential multiplier.
// Exports the controller state encoding and the iteration counter width.
// No ports; import with `import mult_pkg::*;`.
package mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter must be able to represent 0..w, one value per multiplier bit plus headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: shift-add datapath holding multiplicand D, multiplier M and partial product P.
// Ports: clk, rst (sync, active-high), load (capture a/b, clear P), step (one shift-add iteration),
//        a/b operands, p_next (P after the current iteration's conditional add, combinational).
module seq_mult_dp #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p_next
);

  logic [2*WIDTH-1:0] d_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;

  // Sum cannot exceed 2*WIDTH bits since the full product fits there.
  assign p_next = m_q[0] ? (p_q + d_q) : p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      m_q <= '0;
      p_q <= '0;
    end else if (load) begin
      d_q <= {{WIDTH{1'b0}}, a};
      m_q <= b;
      p_q <= '0;
    end else if (step) begin
      p_q <= p_next;
      d_q <= d_q << 1;
      m_q <= m_q >> 1;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: parametrised unsigned sequential multiplier, one multiplier bit per clock.
// Ports: clk, rst (sync, active-high), start (accepted only when idle), A/B operands,
//        busy (operation in flight), done (one-cycle result strobe), result (held until next done).
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;

  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] p_next;

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .a      (A),
    .b      (B),
    .p_next (p_next)
  );

  // Final iteration happens on the edge where cnt still reads WIDTH-1.
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (load) begin
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          result_q <= p_next;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: scoreboard bench for seq_mult at WIDTH 2, 4 and 8.
// Stimulus pushes expected product and completion cycle; per-instance monitors pop on done.
module tb_seq_mult;

  typedef struct {
    logic [15:0] res;
    int          at;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;

  logic       rst2, start2, busy2, done2;
  logic [1:0] a2, b2;
  logic [3:0] res2;

  logic       rst4, start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] res4;

  logic       rst8, start8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] res8;

  exp_t q2[$];
  exp_t q4[$];
  exp_t q8[$];

  seq_mult #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst2), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .result(res2)
  );
  seq_mult #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .result(res4)
  );
  seq_mult #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: done with no pending operation got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // Monitors: compare product and completion cycle whenever done is presented.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) unexpected("done2_spurious");
      else begin
        e = q2.pop_front();
        chk("res2", res2, e.res);
        chk("lat2", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) unexpected("done4_spurious");
      else begin
        e = q4.pop_front();
        chk("res4", res4, e.res);
        chk("lat4", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) unexpected("done8_spurious");
      else begin
        e = q8.pop_front();
        chk("res8", res8, e.res);
        chk("lat8", cyc, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst2 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) tick();

    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_res2", res2, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_res4", res4, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_res8", res8, 0);
    rst2 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    tick();

    // WIDTH=2 legacy case: 2*3 = 6, busy for two cycles, done in the third.
    a2 = 2'b10; b2 = 2'b11; start2 = 1'b1;
    q2.push_back('{res: 16'd6, at: cyc + 1 + 2});
    tick();
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
    chk("w2_busy_c1", busy2, 1);
    tick();
    chk("w2_busy_c2", busy2, 1);
    tick();
    chk("w2_busy_c3", busy2, 0);
    chk("w2_done_c3", done2, 1);
    tick();
    chk("w2_done_c4", done2, 0);
    chk("w2_hold", res2, 6);

    // WIDTH=4 exhaustive with start held high: each new operand pair is
    // accepted in the done cycle of the previous one (period 5 edges).
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        q4.push_back('{res: 16'(a * b), at: cyc + 1 + 4});
        repeat (5) tick();
      end
    end
    start4 = 1'b0;
    chk("w4_last_225", res4, 225);
    repeat (2) tick();

    // start during busy is ignored: 3*5 only, 7*7 never runs.
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    q4.push_back('{res: 16'd15, at: cyc + 1 + 4});
    tick();
    a4 = 4'd7; b4 = 4'd7;
    chk("w4_ign_busy", busy4, 1);
    repeat (2) tick();
    start4 = 1'b0;
    repeat (6) tick();
    chk("w4_ign_res", res4, 15);

    // Reset mid-operation aborts with no done and clears result.
    a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
    q4.push_back('{res: 16'd132, at: cyc + 1 + 4});
    tick();
    start4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    void'(q4.pop_back());
    chk("w4_abort_busy", busy4, 0);
    chk("w4_abort_done", done4, 0);
    chk("w4_abort_res", res4, 0);
    repeat (6) tick();
    chk("w4_abort_quiet", busy4, 0);

    a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
    q4.push_back('{res: 16'd132, at: cyc + 1 + 4});
    tick();
    start4 = 1'b0;
    repeat (6) tick();
    chk("w4_fresh_res", res4, 132);

    // Reset wins over start on the same edge.
    rst4 = 1'b1; start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    tick();
    rst4 = 1'b0; start4 = 1'b0;
    chk("w4_rststart_busy", busy4, 0);
    chk("w4_rststart_res", res4, 0);
    repeat (6) tick();
    chk("w4_rststart_idle", busy4, 0);

    // WIDTH=8 full-scale: 255*255 = 65025, held through idle cycles.
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    q8.push_back('{res: 16'd65025, at: cyc + 1 + 8});
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (8) tick();
    chk("w8_done", done8, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w8_hold", res8, 65025);
      chk("w8_no_done", done8, 0);
    end

    chk("pending_ops", q2.size() + q4.size() + q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
